// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: FSM encodings, owner IDs and shared constants for the data-RAM arbiter
package ram_arbiter_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner selection (round-robin, or m0 priority with RAM_ARB_M0_PRIO_EN)
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic lock,
  input  logic owner,
  output logic vld,
  output logic gnt
);
`ifdef RAM_ARB_M0_PRIO_EN
  logic unused_last;
  assign unused_last = last;
  always_comb begin
    vld = lock ? (owner ? req1 : req0) : (req0 | req1);
    gnt = lock ? owner : (req0 ? OWNER_M0 : OWNER_M1);
  end
`else
  always_comb begin
    vld = lock ? (owner ? req1 : req0) : (req0 | req1);
    gnt = lock ? owner : (req0 & req1) ? ~last : (req0 ? OWNER_M0 : OWNER_M1);
  end
`endif
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master req/ack arbiter for the single-port data RAM; RAM_ARB_M0_PRIO_EN gives m0 fixed priority
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_data_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic                m0_lock_i,
  output logic                m0_ack_o,
  output logic [DATA_W-1:0]   m0_data_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_data_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic                m1_lock_i,
  output logic                m1_ack_o,
  output logic [DATA_W-1:0]   m1_data_o,
  output logic                ram_we_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_data_o,
  output logic [DATA_W/8-1:0] ram_sel_o,
  input  logic [DATA_W-1:0]   ram_data_i
);
  logic [1:0] state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, lock_q, lock_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic idle, acc, resp, vld, gnt, own_we, own_lock;
  ram_arb_pick u_pick (
    .req0  (m0_req_i),
    .req1  (m1_req_i),
    .last  (last_q),
    .lock  (lock_q),
    .owner (owner_q),
    .vld   (vld),
    .gnt   (gnt)
  );
  always_comb begin
    idle = state_q == ST_IDLE;
    acc = state_q == ST_ACCESS;
    resp = state_q == ST_RESP;
    own_we = owner_q ? m1_we_i : m0_we_i;
    own_lock = owner_q ? m1_lock_i : m0_lock_i;
    ram_we_o = acc && own_we == WRITE_ENABLE;
    ram_addr_o = acc ? (owner_q ? m1_addr_i : m0_addr_i) : addr_q;
    ram_data_o = acc ? (owner_q ? m1_data_i : m0_data_i) : wdata_q;
    ram_sel_o = acc ? (owner_q ? m1_sel_i : m0_sel_i) : '0;
    addr_d = ram_addr_o;
    wdata_d = ram_data_o;
    state_d = idle ? (vld ? ST_ACCESS : ST_IDLE) : acc ? ST_RESP : ST_IDLE;
    owner_d = (idle && vld) ? gnt : owner_q;
    last_d = resp ? owner_q : last_q;
    // an idle cycle with the locked owner absent drops the lock so the other master cannot starve
    lock_d = resp ? own_lock : (idle && !vld) ? 1'b0 : lock_q;
    m0_rdata_d = (acc && owner_q == OWNER_M0) ? ram_data_i : m0_rdata_q;
    m1_rdata_d = (acc && owner_q == OWNER_M1) ? ram_data_i : m1_rdata_q;
    m0_ack_o = resp && owner_q == OWNER_M0;
    m1_ack_o = resp && owner_q == OWNER_M1;
    m0_data_o = m0_rdata_q;
    m1_data_o = m1_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_M0;
      last_q <= OWNER_M1;
      lock_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      lock_q <= lock_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0] m0_sel = 0, m1_sel = 0;
  logic m0_ack_o, m1_ack_o, ram_we_o;
  logic [31:0] m0_data_o, m1_data_o, ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0] ram_sel_o;
  logic [31:0] mem [0:255];
  logic [31:0] rd, a0, a1;
  int n_tests = 0, n_fail = 0;
  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
    .m0_sel_i(m0_sel), .m0_lock_i(m0_lock), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
    .m1_sel_i(m1_sel), .m1_lock_i(m1_lock), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_sel_o(ram_sel_o), .ram_data_i(ram_data_i)
  );
  always #5 clk = ~clk;
  assign ram_data_i = mem[ram_addr_o[9:2]];
  always @(posedge clk)
    if (ram_we_o)
      for (int b = 0; b < 4; b++)
        if (ram_sel_o[b]) mem[ram_addr_o[9:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] sel, input logic lk);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = data; m0_sel = sel; m0_lock = lk;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = data; m1_sel = sel; m1_lock = lk;
    end
  endtask
  // starts in IDLE, waits (bounded) for the ack, returns in IDLE
  task automatic xfer(input int m, input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] sel, input string tag, output logic [31:0] rdo);
    int c = 0;
    logic ack = 1'b0;
    drive(m, 1'b1, we, addr, data, sel, 1'b0);
    do begin
      tick;
      c++;
      ack = (m == 0) ? m0_ack_o : m1_ack_o;
    end while (!ack && c < 20);
    chk({tag, "_latency"}, c, 2);
    rdo = (m == 0) ? m0_data_o : m1_data_o;
    drive(m, 1'b0, 1'b0, 0, 0, 4'h0, 1'b0);
    tick;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h11] = 32'h11223344;
    mem[8'h20] = 32'hCAFE0080;
    tick;
    tick;
    chk("rst_m0_ack", {31'd0, m0_ack_o}, 0);
    chk("rst_m1_ack", {31'd0, m1_ack_o}, 0);
    chk("rst_ram_we", {31'd0, ram_we_o}, 0);
    chk("rst_ram_sel", {28'd0, ram_sel_o}, 0);
    chk("rst_ram_addr", ram_addr_o, 0);
    chk("rst_ram_data", ram_data_o, 0);
    chk("rst_m0_data", m0_data_o, 0);
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h40, 0, 4'hF, 1'b0);
    tick;
    chk("rd_access_we", {31'd0, ram_we_o}, 0);
    chk("rd_access_addr", ram_addr_o, 32'h40);
    chk("rd_access_sel", {28'd0, ram_sel_o}, 32'hF);
    chk("rd_access_ack", {31'd0, m0_ack_o}, 0);
    tick;
    chk("rd_resp_ack", {31'd0, m0_ack_o}, 1);
    chk("rd_resp_data", m0_data_o, 32'hDEADBEEF);
    chk("rd_resp_m1_ack", {31'd0, m1_ack_o}, 0);
    drive(0, 1'b0, 1'b0, 0, 0, 4'h0, 1'b0);
    tick;
    chk("rd_idle_ack", {31'd0, m0_ack_o}, 0);
    chk("rd_idle_hold", m0_data_o, 32'hDEADBEEF);
    chk("rd_idle_sel", {28'd0, ram_sel_o}, 0);
    chk("rd_idle_addr_hold", ram_addr_o, 32'h40);
    xfer(1, 1'b1, 32'h44, 32'h000000AB, 4'b0001, "bw_write", rd);
    chk("bw_mem", mem[8'h11], 32'h112233AB);
    xfer(1, 1'b0, 32'h44, 0, 4'hF, "bw_read", rd);
    chk("bw_readback", rd, 32'h112233AB);
    rst = 1'b1;
    tick;
    drive(0, 1'b1, 1'b0, 32'h40, 0, 4'hF, 1'b0);
    drive(1, 1'b1, 1'b0, 32'h44, 0, 4'hF, 1'b0);
    rst = 1'b0;
    a0 = 0; a1 = 0;
    for (int c = 1; c <= 12; c++) begin
      tick;
      a0[c] = m0_ack_o;
      a1[c] = m1_ack_o;
    end
    drive(0, 1'b0, 1'b0, 0, 0, 4'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 0, 0, 4'h0, 1'b0);
`ifdef RAM_ARB_M0_PRIO_EN
    chk("cont_m0_acks", a0, 32'h924);
    chk("cont_m1_acks", a1, 32'h0);
`else
    chk("cont_m0_acks", a0, 32'h104);
    chk("cont_m1_acks", a1, 32'h820);
`endif
    drive(1, 1'b1, 1'b0, 32'h80, 0, 4'hF, 1'b1);
    a0 = 0; a1 = 0;
    for (int c = 1; c <= 9; c++) begin
      tick;
      a0[c] = m0_ack_o;
      a1[c] = m1_ack_o;
      if (c == 1) drive(0, 1'b1, 1'b0, 32'h40, 0, 4'hF, 1'b0);
      if (c == 2) chk("lock_rmw_data", m1_data_o, 32'hCAFE0080);
      if (c == 4) drive(1, 1'b1, 1'b0, 32'h80, 0, 4'hF, 1'b0);
      if (c == 5) drive(1, 1'b0, 1'b0, 0, 0, 4'h0, 1'b0);
      if (c == 8) drive(0, 1'b0, 1'b0, 0, 0, 4'h0, 1'b0);
    end
    chk("lock_m1_acks", a1, 32'h24);
    chk("lock_m0_acks", a0, 32'h100);
    drive(1, 1'b1, 1'b0, 32'h80, 0, 4'hF, 1'b1);
    a0 = 0; a1 = 0;
    for (int c = 1; c <= 7; c++) begin
      tick;
      a0[c] = m0_ack_o;
      a1[c] = m1_ack_o;
      if (c == 2) begin
        drive(1, 1'b0, 1'b0, 0, 0, 4'h0, 1'b1);
        drive(0, 1'b1, 1'b0, 32'h40, 0, 4'hF, 1'b0);
      end
      if (c == 3) chk("rel_idle_sel", {28'd0, ram_sel_o}, 0);
      if (c == 6) begin
        drive(0, 1'b0, 1'b0, 0, 0, 4'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 0, 0, 4'h0, 1'b0);
      end
    end
    chk("rel_m1_acks", a1, 32'h4);
    chk("rel_m0_acks", a0, 32'h40);
    drive(0, 1'b1, 1'b1, 32'h48, 32'h55, 4'hF, 1'b0);
    tick;
    chk("rstmid_we", {31'd0, ram_we_o}, 1);
    chk("rstmid_addr", ram_addr_o, 32'h48);
    rst = 1'b1;
    tick;
    chk("rstmid_no_ack", {31'd0, m0_ack_o}, 0);
    chk("rstmid_idle_sel", {28'd0, ram_sel_o}, 0);
    chk("rstmid_committed", mem[8'h12], 32'h55);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 0, 0, 4'h0, 1'b0);
    xfer(0, 1'b0, 32'h48, 0, 4'hF, "rstmid_read", rd);
    chk("rstmid_readback", rd, 32'h55);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
